// File: rtl/pet_needs_engine.sv
// pet_needs_engine: need levels, health and life-state for a virtual pet.
// N_CH need channels decay on per-channel tick periods and are restored by boost
// pulses. Health erodes while any need is critical, and the pet locks into DEAD
// when health reaches zero. A TEST mode lets an operator poke any value through
// a cursor.
//
// Input handshake: every control input (boost, heal, test_toggle, sel_next,
// test_inc, test_dec) is a single-cycle strobe sampled on the rising clk edge.
// There is no ready/backpressure; a strobe is acted on in the cycle it is high
// or dropped by the mode rules (TEST-only strobes in RUN, everything in DEAD).
module pet_needs_engine #(
  parameter int N_CH     = 4,
  parameter int VAL_W    = 3,
  parameter int VAL_MAX  = 5,
  parameter int WARN_LVL = 3,
  parameter int CRIT_LVL = 2,
  parameter int TICK_DIV = 50,
  parameter int PER_W    = 7,
  parameter int HURT_TK  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH*PER_W-1:0]        decay_per,
  input  logic [N_CH-1:0]              boost,
  input  logic                         heal,
  input  logic                         test_toggle,
  input  logic                         sel_next,
  input  logic                         test_inc,
  input  logic                         test_dec,
  output logic [N_CH*VAL_W-1:0]        levels,
  output logic [VAL_W-1:0]             health,
  output logic [1:0]                   mood,
  output logic [1:0]                   mode,
  output logic [$clog2(N_CH+1)-1:0]    sel,
  output logic [N_CH-1:0]              crit_alarm,
  output logic                         tick
);

  localparam int SEL_W  = $clog2(N_CH + 1);
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HURT_W = $clog2(HURT_TK + 1);

  localparam logic [VAL_W-1:0]  L_MAX      = VAL_W'(VAL_MAX);
  localparam logic [VAL_W-1:0]  L_WARN     = VAL_W'(WARN_LVL);
  localparam logic [VAL_W-1:0]  L_CRIT     = VAL_W'(CRIT_LVL);
  localparam logic [VAL_W-1:0]  L_ONE      = VAL_W'(1);
  localparam logic [VAL_W-1:0]  L_ZERO     = '0;
  localparam logic [DIV_W-1:0]  PRE_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [HURT_W-1:0] HURT_LAST  = HURT_W'(HURT_TK);
  localparam logic [SEL_W-1:0]  SEL_HEALTH = SEL_W'(N_CH);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_TEST = 2'd1,
    MODE_DEAD = 2'd2
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DIV_W-1:0]  pre_q, pre_d;
  logic              tick_q, tick_d;
  logic [VAL_W-1:0]  lvl_q [N_CH];
  logic [VAL_W-1:0]  lvl_d [N_CH];
  logic [VAL_W-1:0]  health_q, health_d;
  logic [PER_W-1:0]  dcnt_q [N_CH];
  logic [PER_W-1:0]  dcnt_d [N_CH];
  logic [HURT_W-1:0] hurt_q, hurt_d;
  logic [1:0]        mood_q, mood_d;
  logic [N_CH-1:0]   was_crit_q, was_crit_d;
  logic [N_CH-1:0]   alarm_q, alarm_d;

  logic [PER_W-1:0]  per [N_CH];
  logic [N_CH-1:0]   decay_ev;
  logic              hurt_ev;
  logic              any_crit;
  logic              any_warn;

  for (genvar g = 0; g < N_CH; g++) begin : g_slice
    assign per[g]                   = decay_per[g*PER_W +: PER_W];
    assign levels[g*VAL_W +: VAL_W] = lvl_q[g];
  end

  assign health     = health_q;
  assign mood       = mood_q;
  assign mode       = mode_q;
  assign sel        = sel_q;
  assign crit_alarm = alarm_q;
  assign tick       = tick_q;

  // Free-running prescaler; tick is high the cycle after the counter wraps.
  always_comb begin
    tick_d = (pre_q == PRE_LAST);
    pre_d  = tick_d ? '0 : pre_q + DIV_W'(1);
  end

  // Threshold summary over the need channels (health handled separately).
  always_comb begin
    any_crit = 1'b0;
    any_warn = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (lvl_q[i] <= L_CRIT) any_crit = 1'b1;
      if (lvl_q[i] <= L_WARN) any_warn = 1'b1;
    end
  end

  // Mode FSM: zero health beats a toggle; DEAD is left only through rst.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN: begin
        if (health_q == L_ZERO)  mode_d = MODE_DEAD;
        else if (test_toggle)    mode_d = MODE_TEST;
      end
      MODE_TEST: begin
        if (health_q == L_ZERO)  mode_d = MODE_DEAD;
        else if (test_toggle)    mode_d = MODE_RUN;
      end
      MODE_DEAD: mode_d = MODE_DEAD;
      default:   mode_d = MODE_DEAD;
    endcase
  end

  // Decay and hurt counters advance on ticks in RUN only and freeze elsewhere.
  always_comb begin
    dcnt_d   = dcnt_q;
    decay_ev = '0;
    hurt_d   = hurt_q;
    hurt_ev  = 1'b0;
    if (mode_q == MODE_RUN) begin
      for (int i = 0; i < N_CH; i++) begin
        if (per[i] == '0) begin
          dcnt_d[i] = '0;
        end else if (tick_q) begin
          if (dcnt_q[i] + PER_W'(1) == per[i]) begin
            decay_ev[i] = 1'b1;
            dcnt_d[i]   = '0;
          end else begin
            dcnt_d[i] = dcnt_q[i] + PER_W'(1);
          end
        end
      end
      if (tick_q) begin
        if (!any_crit) begin
          hurt_d = '0;
        end else if (hurt_q + HURT_W'(1) == HURT_LAST) begin
          hurt_ev = 1'b1;
          hurt_d  = '0;
        end else begin
          hurt_d = hurt_q + HURT_W'(1);
        end
      end
    end
  end

  // Level, health and cursor updates; a pending DEAD clears every value.
  always_comb begin
    lvl_d    = lvl_q;
    health_d = health_q;
    sel_d    = sel_q;
    case (mode_q)
      MODE_RUN: begin
        for (int i = 0; i < N_CH; i++) begin
          if (boost[i] && !decay_ev[i]) begin
            if (lvl_q[i] < L_MAX) lvl_d[i] = lvl_q[i] + L_ONE;
          end else if (decay_ev[i] && !boost[i]) begin
            if (lvl_q[i] > L_ONE) lvl_d[i] = lvl_q[i] - L_ONE;
          end
        end
        if (heal && !hurt_ev) begin
          if (health_q < L_MAX) health_d = health_q + L_ONE;
        end else if (hurt_ev && !heal) begin
          if (health_q > L_ZERO) health_d = health_q - L_ONE;
        end
      end
      MODE_TEST: begin
        if (!test_toggle) begin
          if (sel_next) sel_d = (sel_q >= SEL_HEALTH) ? '0 : sel_q + SEL_W'(1);
          if (test_inc != test_dec) begin
            if (sel_q == SEL_HEALTH) begin
              if (test_inc && health_q < L_MAX)  health_d = health_q + L_ONE;
              if (test_dec && health_q > L_ZERO) health_d = health_q - L_ONE;
            end
            for (int i = 0; i < N_CH; i++) begin
              if (sel_q == SEL_W'(i)) begin
                if (test_inc && lvl_q[i] < L_MAX)  lvl_d[i] = lvl_q[i] + L_ONE;
                if (test_dec && lvl_q[i] > L_ZERO) lvl_d[i] = lvl_q[i] - L_ONE;
              end
            end
          end
        end
      end
      default: ;
    endcase
    if (mode_d == MODE_DEAD) begin
      for (int i = 0; i < N_CH; i++) lvl_d[i] = '0;
      health_d = '0;
    end
  end

  // Mood and critical-entry alarms, both one cycle behind the values.
  always_comb begin
    if (mode_q == MODE_DEAD)                         mood_d = 2'd3;
    else if (any_crit || health_q <= L_CRIT)         mood_d = 2'd2;
    else if (any_warn || health_q <= L_WARN)         mood_d = 2'd1;
    else                                             mood_d = 2'd0;
    was_crit_d = '0;
    alarm_d    = '0;
    for (int i = 0; i < N_CH; i++) begin
      was_crit_d[i] = (lvl_q[i] <= L_CRIT);
      alarm_d[i]    = was_crit_d[i] && !was_crit_q[i] &&
                      (mode_q != MODE_DEAD) && (mode_d != MODE_DEAD);
    end
  end

  // State registers with synchronous reset to a full, healthy, running pet.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_RUN;
      sel_q      <= '0;
      pre_q      <= '0;
      tick_q     <= 1'b0;
      health_q   <= L_MAX;
      hurt_q     <= '0;
      mood_q     <= 2'd0;
      was_crit_q <= '0;
      alarm_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        lvl_q[i]  <= L_MAX;
        dcnt_q[i] <= '0;
      end
    end else begin
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      health_q   <= health_d;
      hurt_q     <= hurt_d;
      mood_q     <= mood_d;
      was_crit_q <= was_crit_d;
      alarm_q    <= alarm_d;
      for (int i = 0; i < N_CH; i++) begin
        lvl_q[i]  <= lvl_d[i];
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pet_needs_engine.sv
// Bench for pet_needs_engine: directed scenarios with fixed expectations plus a
// randomized run, every cycle compared against a behavioural model of the pet.
module tb_pet_needs_engine;

  localparam int N_CH     = 4;
  localparam int VAL_W    = 3;
  localparam int VAL_MAX  = 5;
  localparam int WARN_LVL = 3;
  localparam int CRIT_LVL = 2;
  localparam int TICK_DIV = 50;
  localparam int PER_W    = 7;
  localparam int HURT_TK  = 10;
  localparam int SEL_W    = $clog2(N_CH + 1);
  localparam int SNAP_W   = N_CH*VAL_W + VAL_W + 2 + 2 + SEL_W + N_CH + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_CH*PER_W-1:0]  decay_per = '0;
  logic [N_CH-1:0]        boost = '0;
  logic                   heal = 1'b0;
  logic                   test_toggle = 1'b0;
  logic                   sel_next = 1'b0;
  logic                   test_inc = 1'b0;
  logic                   test_dec = 1'b0;
  logic [N_CH*VAL_W-1:0]  levels;
  logic [VAL_W-1:0]       health;
  logic [1:0]             mood;
  logic [1:0]             mode;
  logic [SEL_W-1:0]       sel;
  logic [N_CH-1:0]        crit_alarm;
  logic                   tick;

  pet_needs_engine #(
    .N_CH(N_CH), .VAL_W(VAL_W), .VAL_MAX(VAL_MAX), .WARN_LVL(WARN_LVL),
    .CRIT_LVL(CRIT_LVL), .TICK_DIV(TICK_DIV), .PER_W(PER_W), .HURT_TK(HURT_TK)
  ) dut (
    .clk(clk), .rst(rst), .decay_per(decay_per), .boost(boost), .heal(heal),
    .test_toggle(test_toggle), .sel_next(sel_next), .test_inc(test_inc),
    .test_dec(test_dec), .levels(levels), .health(health), .mood(mood),
    .mode(mode), .sel(sel), .crit_alarm(crit_alarm), .tick(tick)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pet state as plain integers; modes 0 RUN, 1 TEST, 2 DEAD.
  int m_lvl [N_CH];
  int m_prev [N_CH];
  int m_dc [N_CH];
  int m_hp, m_mode, m_sel, m_mood, m_hurt;
  bit [N_CH-1:0] m_alarm;
  bit m_tick;
  int since_rst = 0;

  function automatic int up(int v);
    return (v < VAL_MAX) ? v + 1 : v;
  endfunction

  function automatic int down(int v, int fl);
    return (v > fl) ? v - 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_lvl[i] = VAL_MAX; m_prev[i] = VAL_MAX; m_dc[i] = 0;
    end
    m_hp = VAL_MAX; m_mode = 0; m_sel = 0; m_mood = 0; m_hurt = 0;
    m_alarm = '0; m_tick = 1'b0; since_rst = 0;
  endtask

  task automatic model_step();
    int nl [N_CH];
    int nh, nmode, nsel, nmood, per;
    bit crit_any, warn_any, hurt, decay;
    bit [N_CH-1:0] nalarm;
    if (rst) begin
      model_reset();
      return;
    end
    since_rst++;
    nl = m_lvl; nh = m_hp; nsel = m_sel; nmode = m_mode;
    crit_any = 1'b0; warn_any = 1'b0; hurt = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (m_lvl[i] <= CRIT_LVL) crit_any = 1'b1;
      if (m_lvl[i] <= WARN_LVL) warn_any = 1'b1;
    end
    if (m_mode != 2 && m_hp == 0)      nmode = 2;
    else if (m_mode != 2 && test_toggle) nmode = 1 - m_mode;
    if (m_mode == 0) begin
      for (int i = 0; i < N_CH; i++) begin
        decay = 1'b0;
        per = int'(decay_per[i*PER_W +: PER_W]);
        if (per == 0) m_dc[i] = 0;
        else if (m_tick) begin
          m_dc[i]++;
          if (m_dc[i] == per) begin decay = 1'b1; m_dc[i] = 0; end
        end
        if (boost[i] && !decay)      nl[i] = up(m_lvl[i]);
        else if (decay && !boost[i]) nl[i] = down(m_lvl[i], 1);
      end
      if (m_tick) begin
        if (crit_any) begin
          m_hurt++;
          if (m_hurt == HURT_TK) begin hurt = 1'b1; m_hurt = 0; end
        end else m_hurt = 0;
      end
      if (heal && !hurt)      nh = up(m_hp);
      else if (hurt && !heal) nh = down(m_hp, 0);
    end else if (m_mode == 1 && !test_toggle) begin
      if (test_inc && !test_dec) begin
        if (m_sel == N_CH) nh = up(m_hp); else nl[m_sel] = up(m_lvl[m_sel]);
      end
      if (test_dec && !test_inc) begin
        if (m_sel == N_CH) nh = down(m_hp, 0); else nl[m_sel] = down(m_lvl[m_sel], 0);
      end
      if (sel_next) nsel = (m_sel + 1) % (N_CH + 1);
    end
    if (nmode == 2) begin
      for (int i = 0; i < N_CH; i++) nl[i] = 0;
      nh = 0;
    end
    if (m_mode == 2)                          nmood = 3;
    else if (crit_any || m_hp <= CRIT_LVL)    nmood = 2;
    else if (warn_any || m_hp <= WARN_LVL)    nmood = 1;
    else                                      nmood = 0;
    for (int i = 0; i < N_CH; i++)
      nalarm[i] = (m_mode != 2) && (nmode != 2) && (m_lvl[i] <= CRIT_LVL) && (m_prev[i] > CRIT_LVL);
    m_prev = m_lvl; m_lvl = nl; m_hp = nh; m_mode = nmode; m_sel = nsel;
    m_mood = nmood; m_alarm = nalarm;
    m_tick = (since_rst % TICK_DIV == 0);
  endtask

  function automatic logic [SNAP_W-1:0] model_snap();
    logic [N_CH*VAL_W-1:0] lv;
    for (int i = 0; i < N_CH; i++) lv[i*VAL_W +: VAL_W] = VAL_W'(m_lvl[i]);
    return {lv, VAL_W'(m_hp), 2'(m_mood), 2'(m_mode), SEL_W'(m_sel), m_alarm, m_tick};
  endfunction

  // ---------------- scoreboard ----------------
  logic [SNAP_W-1:0] exp_q[$];
  logic [SNAP_W-1:0] exp_snap;

  always @(posedge clk) begin
    model_step();
    exp_q.push_back(model_snap());
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_snap = exp_q.pop_front();
      check_val("snapshot", 64'({levels, health, mood, mode, sel, crit_alarm, tick}), 64'(exp_snap));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [VAL_W-1:0] lvl_of(int i);
    return levels[i*VAL_W +: VAL_W];
  endfunction

  task automatic clear_inputs();
    boost = '0; heal = 1'b0; test_toggle = 1'b0;
    sel_next = 1'b0; test_inc = 1'b0; test_dec = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic goto_edge(input int n);
    int guard = 0;
    while (since_rst < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check_val("edge_sync", 64'(since_rst), 64'(n));
  endtask

  task automatic pulse(input bit tg, input bit nx, input bit inc, input bit dec,
                       input logic [N_CH-1:0] bst, input bit hl);
    test_toggle = tg; sel_next = nx; test_inc = inc; test_dec = dec;
    boost = bst; heal = hl;
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  int alarm_cnt;

  initial begin
    @(negedge clk);

    // Scenario 1: channel 0 decays every 4 ticks down to a floor of 1.
    decay_per = {7'd0, 7'd0, 7'd0, 7'd4};
    do_reset();
    check_val("rst_levels", 64'(levels), 64'({3'd5, 3'd5, 3'd5, 3'd5}));
    check_val("rst_health", 64'(health), 64'd5);
    check_val("rst_mode", 64'(mode), 64'd0);
    check_val("rst_tick", 64'(tick), 64'd0);
    goto_edge(200);
    check_val("s1_tick4_strobe", 64'(tick), 64'd1);
    check_val("s1_before_decay", 64'(lvl_of(0)), 64'd5);
    goto_edge(201);
    check_val("s1_first_decay", 64'(lvl_of(0)), 64'd4);
    goto_edge(801);
    check_val("s1_tick16", 64'(lvl_of(0)), 64'd1);
    goto_edge(1201);
    check_val("s1_floor", 64'(lvl_of(0)), 64'd1);
    check_val("s1_others", 64'(levels[N_CH*VAL_W-1:VAL_W]), 64'({3'd5, 3'd5, 3'd5}));

    // Scenario 2: channel 0 parked at 2; one alarm, health drops at tick 10.
    decay_per = '0;
    do_reset();
    pulse(1, 0, 0, 0, '0, 0);
    repeat (3) pulse(0, 0, 0, 1, '0, 0);
    pulse(1, 0, 0, 0, '0, 0);
    check_val("s2_level", 64'(lvl_of(0)), 64'd2);
    alarm_cnt = 0;
    while (since_rst < 500) begin
      if (crit_alarm[0]) alarm_cnt++;
      @(negedge clk);
    end
    check_val("s2_health_pre", 64'(health), 64'd5);
    check_val("s2_mood", 64'(mood), 64'd2);
    goto_edge(501);
    check_val("s2_health_hurt", 64'(health), 64'd4);
    check_val("s2_alarm_once", 64'(alarm_cnt), 64'd1);
    check_val("s2_mood_after", 64'(mood), 64'd2);

    // Scenario 3: boost on the decay cycle cancels out; boost at full saturates.
    decay_per = {7'd0, 7'd0, 7'd2, 7'd0};
    do_reset();
    goto_edge(101);
    check_val("s3_decay", 64'(lvl_of(1)), 64'd4);
    goto_edge(200);
    pulse(0, 0, 0, 0, 4'b0010, 0);
    check_val("s3_boost_vs_decay", 64'(lvl_of(1)), 64'd4);
    goto_edge(301);
    check_val("s3_decay_again", 64'(lvl_of(1)), 64'd3);
    pulse(0, 0, 0, 0, 4'b0110, 0);
    check_val("s3_boost_up", 64'(lvl_of(1)), 64'd4);
    check_val("s3_boost_sat", 64'(lvl_of(2)), 64'd5);

    // Scenario 4: drain health from TEST into DEAD; DEAD ignores inputs.
    decay_per = '0;
    do_reset();
    pulse(1, 0, 0, 0, '0, 0);
    repeat (4) pulse(0, 1, 0, 0, '0, 0);
    check_val("s4_sel_health", 64'(sel), 64'd4);
    repeat (5) pulse(0, 0, 0, 1, '0, 0);
    check_val("s4_health_zero", 64'(health), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check_val("s4_mode_dead", 64'(mode), 64'd2);
    check_val("s4_mood_dead", 64'(mood), 64'd3);
    check_val("s4_levels_zero", 64'(levels), 64'd0);
    pulse(1, 1, 1, 0, 4'b1111, 1);
    pulse(0, 0, 0, 0, 4'b1111, 1);
    repeat (3) @(negedge clk);
    check_val("s4_still_dead", 64'(mode), 64'd2);
    check_val("s4_still_zero", 64'({levels, health}), 64'd0);
    check_val("s4_no_alarm", 64'(crit_alarm), 64'd0);

    // Scenario 5: reset from DEAD mid-tick; next tick exactly TICK_DIV later.
    repeat (30) @(negedge clk);
    do_reset();
    check_val("s5_levels", 64'(levels), 64'({3'd5, 3'd5, 3'd5, 3'd5}));
    check_val("s5_health", 64'(health), 64'd5);
    check_val("s5_mode", 64'(mode), 64'd0);
    check_val("s5_sel", 64'(sel), 64'd0);
    goto_edge(TICK_DIV - 1);
    check_val("s5_no_tick_early", 64'(tick), 64'd0);
    check_val("s5_mood", 64'(mood), 64'd0);
    goto_edge(TICK_DIV);
    check_val("s5_tick", 64'(tick), 64'd1);

    // Scenario 6: inc+dec cancel; toggle beats sel_next; sel persists.
    pulse(1, 0, 0, 0, '0, 0);
    pulse(0, 1, 0, 0, '0, 0);
    pulse(0, 0, 0, 1, '0, 0);
    pulse(0, 0, 1, 1, '0, 0);
    check_val("s6_inc_dec", 64'(lvl_of(1)), 64'd4);
    pulse(1, 1, 0, 0, '0, 0);
    check_val("s6_toggle_mode", 64'(mode), 64'd0);
    check_val("s6_toggle_sel", 64'(sel), 64'd1);
    pulse(1, 0, 0, 0, '0, 0);
    check_val("s6_sel_persist", 64'(sel), 64'd1);
    check_val("s6_back_test", 64'(mode), 64'd1);

    // Randomized run, scored cycle-by-cycle against the model.
    for (int seg = 0; seg < 3; seg++) begin
      for (int i = 0; i < N_CH; i++)
        decay_per[i*PER_W +: PER_W] = PER_W'($urandom_range(0, 5));
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < N_CH; i++) boost[i] = ($urandom_range(0, 11) == 0);
        heal        = ($urandom_range(0, 14) == 0);
        test_toggle = ($urandom_range(0, 39) == 0);
        sel_next    = ($urandom_range(0, 5) == 0);
        test_inc    = ($urandom_range(0, 7) == 0);
        test_dec    = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      clear_inputs();
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
